// File: rtl/e203_tcm_sram_mb_if.sv
// Request/response port between a TCM controller and the multi-bank SRAM front-end.
interface e203_tcm_sram_mb_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AW-1:0]     req_addr;
  logic [DW/8-1:0]   req_wem;
  logic [DW-1:0]     req_wdat;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdat;

  modport master (
    output req_valid, req_we, req_addr, req_wem, req_wdat,
    input  req_ready, rsp_valid, rsp_rdat
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wem, req_wdat,
    output req_ready, rsp_valid, rsp_rdat
  );
endinterface

// File: rtl/e203_tcm_sram_mb.sv
// Multi-bank TCM SRAM front-end: word-interleaved bank select, per-bank power-state
// machines driving ls/ds/sd, and wake stalls through the request handshake.
module e203_tcm_sram_mb #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 14,
  parameter int unsigned BANKS    = 2,
  parameter int unsigned LS_IDLE  = 16,
  parameter int unsigned DS_IDLE  = 256,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  e203_tcm_sram_mb_if.slave              bus,
  input  logic                           sd_req,
  output logic [BANKS-1:0]               ram_cs,
  output logic                           ram_we,
  output logic [AW-$clog2(BANKS)-1:0]    ram_addr,
  output logic [DW/8-1:0]                ram_wem,
  output logic [DW-1:0]                  ram_din,
  input  logic [BANKS*DW-1:0]            ram_dout,
  output logic [BANKS-1:0]               ram_ls,
  output logic [BANKS-1:0]               ram_ds,
  output logic [BANKS-1:0]               ram_sd
);

  localparam int unsigned BW  = $clog2(BANKS);
  localparam int unsigned BIW = (BW > 0) ? BW : 1;
  localparam int unsigned CW  = $clog2(DS_IDLE + 1);
  localparam int unsigned WCW = $clog2(WAKE_CYC + 1);

  typedef enum logic [2:0] {ST_ACT, ST_LS, ST_DS, ST_SD, ST_WAKE} pstate_e;

  pstate_e          state_q [BANKS];
  pstate_e          state_d [BANKS];
  logic [CW-1:0]    cnt_q   [BANKS];
  logic [CW-1:0]    cnt_d   [BANKS];
  logic [CW-1:0]    cnt_inc_c [BANKS];
  logic [WCW-1:0]   wake_q  [BANKS];
  logic [WCW-1:0]   wake_d  [BANKS];
  logic [BANKS-1:0] hit_c;
  logic [BIW-1:0]   bank_c;
  logic [BIW-1:0]   bank_q;
  logic             accept_c;
  logic             rsp_valid_q;

  if (BANKS > 1) begin : g_bank_sel
    assign bank_c = bus.req_addr[BIW-1:0];
  end else begin : g_bank_one
    assign bank_c = '0;
  end

  // Handshake and shared macro buses follow the request combinationally.
  assign accept_c      = bus.req_valid & (state_q[bank_c] == ST_ACT) & ~sd_req;
  assign bus.req_ready = accept_c;
  assign ram_we        = bus.req_we;
  assign ram_addr      = bus.req_addr[AW-1:BW];
  assign ram_wem       = bus.req_wem;
  assign ram_din       = bus.req_wdat;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdat  = ram_dout[bank_q*DW +: DW];

  always_comb begin
    ram_cs = '0;
    if (accept_c) ram_cs[bank_c] = 1'b1;
  end

  always_comb begin
    hit_c = '0;
    for (int b = 0; b < BANKS; b++) begin
      hit_c[b]     = bus.req_valid && (bank_c == BIW'(b));
      cnt_inc_c[b] = (cnt_q[b] == CW'(DS_IDLE)) ? cnt_q[b] : cnt_q[b] + CW'(1);
    end
  end

  // Per-bank power-state next-state logic; shutdown outranks every other transition.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      wake_d[b]  = wake_q[b];
      if (sd_req && (state_q[b] != ST_SD)) begin
        state_d[b] = ST_SD;
        cnt_d[b]   = '0;
      end else begin
        case (state_q[b])
          ST_ACT: begin
            if (hit_c[b]) begin
              cnt_d[b] = '0;
            end else begin
              cnt_d[b] = cnt_inc_c[b];
              if (cnt_inc_c[b] >= CW'(LS_IDLE)) state_d[b] = ST_LS;
            end
          end
          ST_LS: begin
            if (cnt_inc_c[b] >= CW'(DS_IDLE)) begin
              state_d[b] = ST_DS;
              cnt_d[b]   = cnt_inc_c[b];
            end else if (hit_c[b]) begin
              state_d[b] = ST_WAKE;
              cnt_d[b]   = '0;
              wake_d[b]  = WCW'(1);
            end else begin
              cnt_d[b] = cnt_inc_c[b];
            end
          end
          ST_DS, ST_SD: begin
            if (hit_c[b] && !sd_req) begin
              state_d[b] = ST_WAKE;
              cnt_d[b]   = '0;
              wake_d[b]  = WCW'(WAKE_CYC);
            end
          end
          ST_WAKE: begin
            if (wake_q[b] <= WCW'(1)) state_d[b] = ST_ACT;
            else                      wake_d[b]  = wake_q[b] - WCW'(1);
          end
          default: state_d[b] = ST_ACT;
        endcase
      end
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      ram_ls[b] = (state_q[b] == ST_LS);
      ram_ds[b] = (state_q[b] == ST_DS);
      ram_sd[b] = (state_q[b] == ST_SD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        state_q[b] <= ST_ACT;
        cnt_q[b]   <= '0;
        wake_q[b]  <= '0;
      end
      rsp_valid_q <= 1'b0;
      bank_q      <= '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        wake_q[b]  <= wake_d[b];
      end
      rsp_valid_q <= accept_c & ~bus.req_we;
      if (accept_c && !bus.req_we) bank_q <= bank_c;
    end
  end

endmodule

// File: tb/tb_e203_tcm_sram_mb.sv
// Bench for e203_tcm_sram_mb: behavioural bank macros, reference memory and a read scoreboard.
module tb_e203_tcm_sram_mb;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 14;
  localparam int unsigned BANKS = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  sd_req;
  logic [BANKS-1:0]      ram_cs;
  logic                  ram_we;
  logic [AW-2:0]         ram_addr;
  logic [DW/8-1:0]       ram_wem;
  logic [DW-1:0]         ram_din;
  logic [BANKS*DW-1:0]   ram_dout;
  logic [BANKS-1:0]      ram_ls;
  logic [BANKS-1:0]      ram_ds;
  logic [BANKS-1:0]      ram_sd;
  logic [DW-1:0]         dout_q [BANKS];

  logic [DW-1:0]         mem     [int];
  logic [DW-1:0]         ref_mem [int];
  logic [DW-1:0]         rsp_q   [$];
  logic [DW-1:0]         mon_exp;

  int checks   = 0;
  int failures = 0;

  e203_tcm_sram_mb_if #(.DW(DW), .AW(AW)) bus ();

  e203_tcm_sram_mb #(
    .DW(DW), .AW(AW), .BANKS(BANKS), .LS_IDLE(16), .DS_IDLE(256), .WAKE_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sd_req(sd_req),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Synchronous-read macro model; key is the full word address.
  always @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (ram_cs[b]) begin
        if (ram_we) begin
          logic [DW-1:0] w;
          w = mem.exists(int'(ram_addr) * 2 + b) ? mem[int'(ram_addr) * 2 + b] : '0;
          for (int k = 0; k < DW/8; k++)
            if (ram_wem[k]) w[k*8 +: 8] = ram_din[k*8 +: 8];
          mem[int'(ram_addr) * 2 + b] = w;
        end else begin
          dout_q[b] <= mem[int'(ram_addr) * 2 + b];
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) ram_dout[b*DW +: DW] = dout_q[b];
  end

  // Scoreboard: responses checked one cycle after accept, then new accepts recorded.
  always @(negedge clk) begin
    if (rsp_q.size() > 0) begin
      mon_exp = rsp_q.pop_front();
      check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("rsp_rdat", 64'(bus.rsp_rdat), 64'(mon_exp));
    end else if (bus.rsp_valid === 1'b1) begin
      check("rsp_spurious", 64'd1, 64'd0);
    end
    if (rst_n && bus.req_valid && bus.req_ready) begin
      if (bus.req_we) begin
        logic [DW-1:0] w;
        w = ref_mem.exists(int'(bus.req_addr)) ? ref_mem[int'(bus.req_addr)] : '0;
        for (int k = 0; k < DW/8; k++)
          if (bus.req_wem[k]) w[k*8 +: 8] = bus.req_wdat[k*8 +: 8];
        ref_mem[int'(bus.req_addr)] = w;
      end else begin
        rsp_q.push_back(ref_mem[int'(bus.req_addr)]);
      end
    end
  end

  // Call just after a rising edge; req_valid rises in that cycle.
  task automatic do_req(input string tag, input logic we, input logic [AW-1:0] addr,
                        input logic [DW/8-1:0] wem, input logic [DW-1:0] wdat,
                        input int exp_stall);
    int stall;
    logic [BANKS-1:0] exp_cs;
    stall = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wem   = wem;
    bus.req_wdat  = wdat;
    @(negedge clk);
    while (!bus.req_ready && stall < 50) begin
      stall++;
      @(negedge clk);
    end
    check({tag, "_stall"}, 64'(stall), 64'(exp_stall));
    if (bus.req_ready) begin
      exp_cs = '0;
      exp_cs[addr[0]] = 1'b1;
      check({tag, "_cs"}, 64'(ram_cs), 64'(exp_cs));
      check({tag, "_addr"}, 64'(ram_addr), 64'(addr[AW-1:1]));
      if (we) begin
        check({tag, "_wem"}, 64'(ram_wem), 64'(wem));
        check({tag, "_din"}, 64'(ram_din), 64'(wdat));
      end
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  initial begin
    int stall;
    rst_n         = 1'b0;
    sd_req        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wem   = '0;
    bus.req_wdat  = '0;
    mem[0] = 32'hCAFE0000;  ref_mem[0] = 32'hCAFE0000;
    mem[1] = 32'hBEEF0001;  ref_mem[1] = 32'hBEEF0001;
    #2;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_cs", 64'(ram_cs), 64'd0);
    check("rst_pins", 64'({ram_ls, ram_ds, ram_sd}), 64'd0);
    #10 rst_n = 1'b1;

    // Idle sequencing from reset: LS at edge 16, DS at edge 256.
    repeat (15) @(negedge clk);
    check("idle_ls_pre", 64'(ram_ls), 64'd0);
    @(negedge clk);
    check("idle_ls", 64'(ram_ls), 64'b11);
    repeat (239) @(negedge clk);
    check("idle_ds_pre", 64'(ram_ds), 64'd0);
    @(negedge clk);
    check("idle_ds", 64'(ram_ds), 64'b11);
    check("idle_ls_off", 64'(ram_ls), 64'd0);

    @(posedge clk); #1;
    do_req("ds_rd0", 1'b0, 14'd0, 4'h0, 32'h0, 3);
    do_req("ds_wr5", 1'b1, 14'd5, 4'hF, 32'hDEADBEEF, 3);
    do_req("act_rd5", 1'b0, 14'd5, 4'h0, 32'h0, 0);
    do_req("bm_wr_full", 1'b1, 14'd6, 4'hF, 32'h11223344, 0);
    do_req("bm_wr_byte", 1'b1, 14'd6, 4'b0010, 32'h0000AB00, 0);
    do_req("bm_rd", 1'b0, 14'd6, 4'h0, 32'h0, 0);
    check("bm_ref", 64'(ref_mem[6]), 64'h1122AB44);

    // Keep bank 0 busy while bank 1 drops into light sleep.
    for (int i = 0; i < 20; i++) do_req("b2b_rd6", 1'b0, 14'd6, 4'h0, 32'h0, 0);
    check("b1_ls", 64'(ram_ls), 64'b10);
    do_req("ls_rd5", 1'b0, 14'd5, 4'h0, 32'h0, 2);
    do_req("il_rd6", 1'b0, 14'd6, 4'h0, 32'h0, 0);
    for (int i = 0; i < 15; i++) do_req("il_rd5", 1'b0, 14'd5, 4'h0, 32'h0, 0);
    @(negedge clk);
    check("b0_idle_ls_pre", 64'(ram_ls), 64'b00);
    @(negedge clk);
    check("b0_idle_ls", 64'(ram_ls), 64'b01);

    // Shutdown with a request to bank 1 held pending.
    @(posedge clk); #1;
    sd_req        = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sd_ready", 64'(bus.req_ready), 64'd0);
      if (i > 0) check("sd_all", 64'(ram_sd), 64'b11);
    end
    @(posedge clk); #1 sd_req = 1'b0;
    stall = 0;
    @(negedge clk);
    while (!bus.req_ready && stall < 50) begin
      stall++;
      @(negedge clk);
    end
    check("sd_wake_stall", 64'(stall), 64'd3);
    check("sd_other_bank", 64'(ram_sd), 64'b01);
    check("sd_wake_cs", 64'(ram_cs), 64'b10);
    @(posedge clk); #1 bus.req_valid = 1'b0;

    // Reset while bank 0 is waking from SD.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 14'd0;
    @(negedge clk);
    @(negedge clk);
    check("wake_ready", 64'(bus.req_ready), 64'd0);
    check("wake_pins", 64'({ram_ls, ram_ds, ram_sd}), 64'd0);
    #2;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_cs", 64'(ram_cs), 64'd0);
    check("mid_rst_pins", 64'({ram_ls, ram_ds, ram_sd}), 64'd0);
    check("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req("post_rst_rd0", 1'b0, 14'd0, 4'h0, 32'h0, 0);
    do_req("post_rst_rd1", 1'b0, 14'd1, 4'h0, 32'h0, 0);

    repeat (3) @(negedge clk);
    if (rsp_q.size() != 0) check("rsp_missing", 64'(rsp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
